ysyx_25040105_core_mc: RTL
==========================

YSYX_25040105_CORE_MC -- requirements
Module: ysyx_25040105_core_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and register width.
REQ-002 SHALL have parameter NR_REGS, default 32: register count, 32 or 16 (RV32E); other values are a synthesis error.
REQ-003 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-007 SHALL have port imem_req_ready, input, 1 bit: memory accepts request.
REQ-008 SHALL have port imem_req_addr, output, XLEN bits: fetch address, always equal to pc.
REQ-009 SHALL have port imem_rsp_valid, input, 1 bit: instruction word valid.
REQ-010 SHALL have port imem_rsp_data, input, 32 bits: instruction word.
REQ-011 SHALL have port pc, output, XLEN bits: architectural PC.
REQ-012 SHALL have port halted, output, 1 bit: core stopped.
REQ-013 SHALL have port halt_illegal, output, 1 bit: stop was caused by an illegal instruction.

Function
REQ-014 SHALL implement FSM FETCH_REQ -> FETCH_WAIT -> EXEC -> WB -> FETCH_REQ, plus a terminal HALT state.
REQ-015 FETCH_REQ SHALL assert imem_req_valid and move to FETCH_WAIT only on the cycle where imem_req_valid and imem_req_ready are both high.
REQ-016 Once asserted, imem_req_valid and imem_req_addr SHALL hold stable until accepted.
REQ-017 FETCH_WAIT SHALL latch imem_rsp_data into the instruction register on imem_rsp_valid; imem_rsp_valid SHALL be ignored in all other states.
REQ-018 Supported instructions SHALL be ADDI, ADD, SUB, LUI, AUIPC, JAL, JALR and EBREAK; any other encoding is illegal.
REQ-019 EXEC SHALL decode and compute alu_result; WB SHALL write rd and update pc (pc+4, JAL pc+imm, JALR (rs1+imm)&~1).
REQ-020 Arithmetic SHALL be XLEN-bit modulo 2^XLEN; immediates SHALL be sign-extended to XLEN.
REQ-021 Writes to x0 SHALL be dropped; reads of x0 SHALL return 0.
REQ-022 When NR_REGS=16, any rs1/rs2/rd index >= 16 SHALL be illegal.
REQ-023 EBREAK or an illegal instruction SHALL enter HALT in WB with no register write and pc unchanged; halt_illegal=1 only for the illegal case.
REQ-024 HALT SHALL be left only by reset, and imem_req_valid SHALL be 0 in HALT.
REQ-025 With zero-wait memory (ready=1, rsp the cycle after acceptance), throughput SHALL be one instruction per 4 cycles.

Reset
REQ-026 While rst=0: state=FETCH_REQ, pc=RESET_PC, all registers=0, halted=0, halt_illegal=0, imem_req_valid=0.
REQ-027 imem_req_valid SHALL rise no earlier than the first clock edge after rst deasserts.
REQ-028 Reset during FETCH_WAIT SHALL abandon the outstanding fetch; a late response SHALL be ignored.

Configuration
REQ-029 With macro YSYX_25040105_COMMIT_TRACE_EN defined: outputs commit_valid (1), commit_pc (XLEN), commit_inst (32), commit_rd (5), commit_wdata (XLEN); commit_valid SHALL pulse for one cycle in WB of every retired instruction, including EBREAK and excluding illegal instructions.
REQ-030 Without the macro, these ports and their logic SHALL be absent, and the core's behaviour SHALL otherwise be identical.

Structure
REQ-031 Package ysyx_25040105_pkg SHALL hold: opcode/funct constants, FSM state enum, ALU-op enum, and the default RESET_PC.
REQ-032 The register file SHALL be sub-module ysyx_25040105_regfile_p (parameters XLEN and NR_REGS, two asynchronous read ports, one synchronous write port, x0 hard-wired to zero).

Verification
REQ-033 Reset release, ready=1 -> first request addr 0x8000_0000 one cycle after release.
REQ-034 ADDI x1,x0,5 then ADD x2,x1,x1 -> x1=5, x2=10, pc=0x8000_0008 after 8 cycles.
REQ-035 imem_req_ready low for 3 cycles -> imem_req_addr stable throughout; a single fetch is performed.
REQ-036 ADDI x0,x0,7 -> x0 reads 0; ADDI x3,x0,-1 with XLEN=32 -> x3=0xFFFF_FFFF.
REQ-037 JALR x1,x2,3 with x2=0x8000_0100 -> pc=0x8000_0102, x1=old pc+4.
REQ-038 NR_REGS=16, ADD x20,x1,x1 -> halted=1, halt_illegal=1, no write; EBREAK -> halted=1, halt_illegal=0.

Source files
------------

// File: rtl/ysyx_25040105_pkg.sv
// ysyx_25040105_pkg
// Shared definitions for the multi-cycle RV32I/E subset core:
//   - default first fetch address
//   - opcode / funct constants and the exact EBREAK encoding
//   - FSM state enum and ALU-op enum
package ysyx_25040105_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   localparam logic [6:0]  OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0]  OPC_OP     = 7'b011_0011;
   localparam logic [6:0]  OPC_LUI    = 7'b011_0111;
   localparam logic [6:0]  OPC_AUIPC  = 7'b001_0111;
   localparam logic [6:0]  OPC_JAL    = 7'b110_1111;
   localparam logic [6:0]  OPC_JALR   = 7'b110_0111;

   localparam logic [2:0]  F3_ADD     = 3'b000;
   localparam logic [6:0]  F7_ADD     = 7'b000_0000;
   localparam logic [6:0]  F7_SUB     = 7'b010_0000;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {
      ST_FETCH_REQ  = 3'd0,
      ST_FETCH_WAIT = 3'd1,
      ST_EXEC       = 3'd2,
      ST_WB         = 3'd3,
      ST_HALT       = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'd0,
      ALU_SUB    = 2'd1,
      ALU_PASS_B = 2'd2
   } alu_op_e;

endpackage

// File: rtl/ysyx_25040105_regfile_p.sv
// ysyx_25040105_regfile_p
// Integer register file: two asynchronous read ports, one synchronous
// write port, x0 hard-wired to zero. NR_REGS must be 32 or 16.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (clears all)
//   raddr1/rdata1       read port 1
//   raddr2/rdata2       read port 2
//   we/waddr/wdata      write port (x0 and out-of-range indices dropped)
module ysyx_25040105_regfile_p #(
   parameter int XLEN    = 32,
   parameter int NR_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      raddr1,
   output logic [XLEN-1:0] rdata1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata2,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata
);

   localparam int AW = $clog2(NR_REGS);

   generate
      if (NR_REGS != 32 && NR_REGS != 16) begin : g_bad_nr_regs
         $error("ysyx_25040105_regfile_p: NR_REGS must be 32 or 16");
      end
   endgenerate

   logic [XLEN-1:0] regs [NR_REGS];
   logic            write_ok;

   assign rdata1   = (raddr1 == 5'd0) ? '0 : regs[raddr1[AW-1:0]];
   assign rdata2   = (raddr2 == 5'd0) ? '0 : regs[raddr2[AW-1:0]];
   assign write_ok = we && (waddr != 5'd0) && ({1'b0, waddr} < 6'(NR_REGS));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
      end else if (write_ok) begin
         regs[waddr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/ysyx_25040105_core_mc.sv
// ysyx_25040105_core_mc
// Multi-cycle core: FETCH_REQ -> FETCH_WAIT -> EXEC -> WB, terminal HALT.
// Supports ADDI, ADD, SUB, LUI, AUIPC, JAL, JALR, EBREAK; anything else halts
// with halt_illegal set.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   imem_req_valid/ready/addr    fetch request channel
//   imem_rsp_valid/data          fetch response (only looked at in FETCH_WAIT)
//   pc                           architectural PC
//   halted, halt_illegal         core stopped / stopped on illegal instruction
// Optional (macro YSYX_25040105_COMMIT_TRACE_EN):
//   commit_valid/pc/inst/rd/wdata  one-cycle retire record in WB
// Handshake: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; once valid is high, it and imem_req_addr hold
// unchanged until that transfer.
module ysyx_25040105_core_mc
   import ysyx_25040105_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NR_REGS  = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic [XLEN-1:0] pc,
   output logic            halted,
   output logic            halt_illegal
`ifdef YSYX_25040105_COMMIT_TRACE_EN
   ,
   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc,
   output logic [31:0]     commit_inst,
   output logic [4:0]      commit_rd,
   output logic [XLEN-1:0] commit_wdata
`endif
);

   state_e          state, state_next;
   logic            run_q;       // holds off the first request until one edge after reset
   logic [XLEN-1:0] pc_q, next_pc_q, wb_data_q;
   logic [31:0]     inst_q;
   logic [4:0]      wb_rd_q;
   logic            wb_we_q, halt_q, illegal_q;

   logic            inst_load, exec_load, pc_load, rf_we;

   // decode / execute
   logic [6:0]      opcode, f7;
   logic [2:0]      f3;
   logic [4:0]      rd, rs1, rs2;
   logic [XLEN-1:0] rs1_data, rs2_data, imm_i, imm_u, imm_j;
   logic [XLEN-1:0] op_a, op_b, alu_result, next_pc;
   alu_op_e         alu_op;
   logic            legal, is_ebreak, rd_we, use_rd, use_rs1, use_rs2, reg_bad, illegal;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_FETCH_REQ;
      else      state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH_REQ:  if (imem_req_valid && imem_req_ready) state_next = ST_FETCH_WAIT;
         ST_FETCH_WAIT: if (imem_rsp_valid) state_next = ST_EXEC;
         ST_EXEC:       state_next = ST_WB;
         ST_WB:         state_next = halt_q ? ST_HALT : ST_FETCH_REQ;
         ST_HALT:       state_next = ST_HALT;
         default:       state_next = ST_FETCH_REQ;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      imem_req_valid = (state == ST_FETCH_REQ) && run_q;
      inst_load      = (state == ST_FETCH_WAIT) && imem_rsp_valid;
      exec_load      = (state == ST_EXEC);
      pc_load        = (state == ST_WB) && !halt_q;
      rf_we          = (state == ST_WB) && wb_we_q;
      halted         = (state == ST_HALT);
      halt_illegal   = (state == ST_HALT) && illegal_q;
   end

   assign imem_req_addr = pc_q;
   assign pc            = pc_q;

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q     <= 1'b0;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         wb_data_q <= '0;
         next_pc_q <= '0;
         wb_rd_q   <= '0;
         wb_we_q   <= 1'b0;
         halt_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (inst_load) inst_q <= imem_rsp_data;
         if (exec_load) begin
            wb_data_q <= alu_result;
            next_pc_q <= next_pc;
            wb_rd_q   <= rd;
            wb_we_q   <= rd_we && !illegal;
            halt_q    <= is_ebreak || illegal;
            illegal_q <= illegal;
         end
         if (pc_load) pc_q <= next_pc_q;
      end
   end

   // ---------------- register file ----------------
   ysyx_25040105_regfile_p #(
      .XLEN    (XLEN),
      .NR_REGS (NR_REGS)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (rs1),
      .rdata1 (rs1_data),
      .raddr2 (rs2),
      .rdata2 (rs2_data),
      .we     (rf_we),
      .waddr  (wb_rd_q),
      .wdata  (wb_data_q)
   );

   // ---------------- decode ----------------
   assign opcode = inst_q[6:0];
   assign rd     = inst_q[11:7];
   assign f3     = inst_q[14:12];
   assign rs1    = inst_q[19:15];
   assign rs2    = inst_q[24:20];
   assign f7     = inst_q[31:25];
   assign imm_i  = XLEN'($signed(inst_q[31:20]));
   assign imm_u  = XLEN'($signed({inst_q[31:12], 12'b0}));
   assign imm_j  = XLEN'($signed({inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0}));

   always_comb begin
      alu_op    = ALU_ADD;
      op_a      = rs1_data;
      op_b      = imm_i;
      next_pc   = pc_q + XLEN'(4);
      legal     = 1'b0;
      is_ebreak = 1'b0;
      rd_we     = 1'b0;
      use_rd    = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      case (opcode)
         OPC_OP_IMM: if (f3 == F3_ADD) begin
            legal = 1'b1; rd_we = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
         end
         OPC_OP: if (f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) begin
            legal = 1'b1; rd_we = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            op_b   = rs2_data;
            alu_op = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
         end
         OPC_LUI: begin
            legal = 1'b1; rd_we = 1'b1; use_rd = 1'b1;
            op_b   = imm_u;
            alu_op = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            legal = 1'b1; rd_we = 1'b1; use_rd = 1'b1;
            op_a = pc_q;
            op_b = imm_u;
         end
         OPC_JAL: begin
            legal = 1'b1; rd_we = 1'b1; use_rd = 1'b1;
            op_a    = pc_q;        // link value pc+4 comes out of the ALU
            op_b    = XLEN'(4);
            next_pc = pc_q + imm_j;
         end
         OPC_JALR: if (f3 == F3_ADD) begin
            legal = 1'b1; rd_we = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
            op_a    = pc_q;
            op_b    = XLEN'(4);
            next_pc = (rs1_data + imm_i) & ~XLEN'(1);
         end
         default: if (inst_q == INST_EBREAK) begin
            legal     = 1'b1;
            is_ebreak = 1'b1;
         end
      endcase
   end

   // RV32E: any referenced register index with bit 4 set does not exist.
   assign reg_bad = (NR_REGS == 16) &&
                    ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));
   assign illegal = !legal || reg_bad;

   // ---------------- ALU ----------------
   always_comb begin
      case (alu_op)
         ALU_SUB:    alu_result = op_a - op_b;
         ALU_PASS_B: alu_result = op_b;
         default:    alu_result = op_a + op_b;
      endcase
   end

`ifdef YSYX_25040105_COMMIT_TRACE_EN
   assign commit_valid = (state == ST_WB) && !illegal_q;
   assign commit_pc    = pc_q;
   assign commit_inst  = inst_q;
   assign commit_rd    = wb_rd_q;
   assign commit_wdata = wb_data_q;
`endif

endmodule
